// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 tables, GF(2^8) helpers and FSM state type shared by the inverse cipher
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Row r of output column c comes from input column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int j = 0; j < 16; j++) begin
            o[127-8*j -: 8] = INV_SBOX[s[127-8*j -: 8]];
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) return RCON[r];
        return 8'h00;
    endfunction

endpackage

// File: rtl/inv_mix_columns.sv
// rtl/inv_mix_columns.sv - combinational InvMixColumns over all four columns of a 128-bit state
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] data,
    output logic [127:0] mixed
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_col(data[127-32*c -: 32]);
        end
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES-128 inverse cipher, one round per clock, key schedule run backwards
// Define AES_DEC_KEY_OUT_EN to add out_key carrying the recovered round-0 key.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef AES_DEC_KEY_OUT_EN
    ,
    output logic [127:0] out_key
`endif
);

    state_t       state;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic [127:0] rk;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [127:0] prev_key;
    logic [127:0] round_out;
    logic [127:0] mix_out;

    // Undo one key-expansion step: recover round key rnd-1 from round key rnd.
    always_comb begin
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon(rnd), 24'h000000};
        prev_key  = {p0, p1, p2, p3};
        round_out = inv_sub_bytes(inv_shift_rows(st)) ^ prev_key;
    end

    inv_mix_columns u_inv_mix_columns (
        .data  (round_out),
        .mixed (mix_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rnd       <= 4'd0;
            st        <= '0;
            rk        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef AES_DEC_KEY_OUT_EN
            out_key   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= in_data ^ in_key;
                        rk       <= in_key;
                        rnd      <= 4'(NR);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rk  <= prev_key;
                    rnd <= rnd - 4'd1;
                    if (rnd == 4'd1) begin
                        st        <= round_out;
                        out_data  <= round_out;
                        out_valid <= 1'b1;
`ifdef AES_DEC_KEY_OUT_EN
                        out_key   <= prev_key;
`endif
                        state     <= DONE;
                    end else begin
                        st <= mix_out;
                    end
                end
                DONE: begin
                    // No accept here: in_ready only returns once the result has left.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - self-checking bench: forward-AES reference model generates ciphertexts for the decryptor
module tb_aes_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef AES_DEC_KEY_OUT_EN
    logic [127:0] out_key;
`endif
    logic [127:0] imc_data;
    logic [127:0] imc_mixed;

    int checks = 0;
    int failures = 0;
    logic [7:0] tb_sbox [256];

    always #5 clk = ~clk;

    aes_decrypt_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef AES_DEC_KEY_OUT_EN
        ,
        .out_key   (out_key)
`endif
    );

    inv_mix_columns u_imc (
        .data  (imc_data),
        .mixed (imc_mixed)
    );

    // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] x);
        logic [7:0] a0, a1, a2, a3;
        a0 = x[31:24]; a1 = x[23:16]; a2 = x[15:8]; a3 = x[7:0];
        return {gf_mul(a0, 8'd2) ^ gf_mul(a1, 8'd3) ^ a2 ^ a3,
                a0 ^ gf_mul(a1, 8'd2) ^ gf_mul(a2, 8'd3) ^ a3,
                a0 ^ a1 ^ gf_mul(a2, 8'd2) ^ gf_mul(a3, 8'd3),
                gf_mul(a0, 8'd3) ^ a1 ^ a2 ^ gf_mul(a3, 8'd2)};
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] v, inv;
        for (int x = 0; x < 256; x++) begin
            v = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(v, 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-128: returns ciphertext and the last round key of the expansion.
    task automatic aes_encrypt(input logic [127:0] pt, input logic [127:0] key,
                               output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t, col;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sbox_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'd2);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ key[127-8*j -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 16; j++) s[j] = tb_sbox[s[j]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) u[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                col = {u[4*c], u[4*c+1], u[4*c+2], u[4*c+3]};
                if (r != 10) col = mix_col(col);
                col = col ^ w[4*r+c];
                s[4*c] = col[31:24]; s[4*c+1] = col[23:16]; s[4*c+2] = col[15:8]; s[4*c+3] = col[7:0];
            end
        end
        for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = s[j];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    // Presents a block and returns at the negedge following the accepting edge.
    task automatic accept_block(input logic [127:0] d, input logic [127:0] k);
        int n;
        n = 0;
        in_data = d;
        in_key = k;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int cnt);
        cnt = start;
        while (out_valid !== 1'b1 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_key = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
`ifdef AES_DEC_KEY_OUT_EN
        checks++;
        if (out_key !== 128'h0) begin failures++; $display("FAIL reset_out_key got=%h exp=0", out_key); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips();
        int cnt;
        out_ready = 1'b1;
        accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        wait_out(0, cnt);
        checks++;
        if (cnt != 10) begin failures++; $display("FAIL c1_latency got=%0d exp=10", cnt); end
        checks++;
        if (out_data !== 128'h00112233445566778899aabbccddeeff) begin
            failures++; $display("FAIL c1_data got=%h exp=00112233445566778899aabbccddeeff", out_data);
        end
`ifdef AES_DEC_KEY_OUT_EN
        checks++;
        if (out_key !== 128'h000102030405060708090a0b0c0d0e0f) begin
            failures++; $display("FAIL c1_key got=%h exp=000102030405060708090a0b0c0d0e0f", out_key);
        end
`endif
        accept_block(128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_out(0, cnt);
        checks++;
        if (cnt != 10) begin failures++; $display("FAIL appb_latency got=%0d exp=10", cnt); end
        checks++;
        if (out_data !== 128'h3243f6a8885a308d313198a2e0370734) begin
            failures++; $display("FAIL appb_data got=%h exp=3243f6a8885a308d313198a2e0370734", out_data);
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, key, ct, k10;
        int cnt;
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            aes_encrypt(pt, key, ct, k10);
            accept_block(ct, k10);
            wait_out(0, cnt);
            checks++;
            if (cnt != 10) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=10", b, cnt); end
            checks++;
            if (out_data !== pt) begin failures++; $display("FAIL rand%0d_data got=%h exp=%h", b, out_data, pt); end
`ifdef AES_DEC_KEY_OUT_EN
            checks++;
            if (out_key !== key) begin failures++; $display("FAIL rand%0d_key got=%h exp=%h", b, out_key, key); end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, key, ct, k10;
        int cnt;
        bit stable;
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        aes_encrypt(pt, key, ct, k10);
        accept_block(ct, k10);
        out_ready = 1'b0;
        wait_out(0, cnt);
        checks++;
        if (out_data !== pt) begin failures++; $display("FAIL bp_data got=%h exp=%h", out_data, pt); end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_data !== pt || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            failures++; $display("FAIL bp_hold got out_valid=%b in_ready=%b data=%h exp 1/0/%h", out_valid, in_ready, out_data, pt);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_busy_input();
        logic [127:0] pt, key, ct, k10;
        int cnt;
        out_ready = 1'b1;
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        aes_encrypt(pt, key, ct, k10);
        accept_block(ct, k10);
        repeat (3) @(negedge clk);
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_key = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(4, cnt);
        checks++;
        if (cnt != 10) begin failures++; $display("FAIL busy_latency got=%0d exp=10", cnt); end
        checks++;
        if (out_data !== pt) begin failures++; $display("FAIL busy_data got=%h exp=%h", out_data, pt); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt1, key1, ct1, k1, pt2, key2, ct2, k2;
        int cnt, gap;
        out_ready = 1'b1;
        pt1 = {$urandom, $urandom, $urandom, $urandom};
        key1 = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        key2 = {$urandom, $urandom, $urandom, $urandom};
        aes_encrypt(pt1, key1, ct1, k1);
        aes_encrypt(pt2, key2, ct2, k2);
        accept_block(ct1, k1);
        in_data = ct2;
        in_key = k2;
        in_valid = 1'b1;
        wait_out(0, cnt);
        checks++;
        if (out_data !== pt1) begin failures++; $display("FAIL b2b_first_data got=%h exp=%h", out_data, pt1); end
        gap = cnt;
        while (in_ready !== 1'b1 && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (gap != 11) begin failures++; $display("FAIL b2b_ready_gap got=%0d exp=11", gap); end
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(0, cnt);
        checks++;
        if (cnt != 10) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=10", cnt); end
        checks++;
        if (out_data !== pt2) begin failures++; $display("FAIL b2b_second_data got=%h exp=%h", out_data, pt2); end
    endtask

    task automatic test_reset_mid_run();
        int cnt;
        bit quiet;
        out_ready = 1'b1;
        accept_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_data !== 128'h0) begin failures++; $display("FAIL midrst_out_data got=%h exp=0", out_data); end
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin failures++; $display("FAIL midrst_partial_output got=0 exp=1"); end
        accept_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        wait_out(0, cnt);
        checks++;
        if (out_data !== 128'h00112233445566778899aabbccddeeff) begin
            failures++; $display("FAIL midrst_c1_data got=%h exp=00112233445566778899aabbccddeeff", out_data);
        end
    endtask

    task automatic test_inv_mix_columns();
        logic [31:0]  rcol;
        logic [127:0] x;
        rcol = $urandom;
        imc_data = {32'h8e4da1bc, 32'h9fdc589d, 32'h00000000, mix_col(rcol)};
        #1;
        checks++;
        if (imc_mixed[127:96] !== 32'hdb135345) begin failures++; $display("FAIL imc_col0 got=%h exp=db135345", imc_mixed[127:96]); end
        checks++;
        if (imc_mixed[95:64] !== 32'hf20a225c) begin failures++; $display("FAIL imc_col1 got=%h exp=f20a225c", imc_mixed[95:64]); end
        checks++;
        if (imc_mixed[63:32] !== 32'h0) begin failures++; $display("FAIL imc_zero got=%h exp=0", imc_mixed[63:32]); end
        checks++;
        if (imc_mixed[31:0] !== rcol) begin failures++; $display("FAIL imc_rand_col got=%h exp=%h", imc_mixed[31:0], rcol); end
        for (int t = 0; t < 4; t++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            imc_data = {mix_col(x[127:96]), mix_col(x[95:64]), mix_col(x[63:32]), mix_col(x[31:0])};
            #1;
            checks++;
            if (imc_mixed !== x) begin failures++; $display("FAIL imc_rand%0d got=%h exp=%h", t, imc_mixed, x); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_key = '0;
        imc_data = '0;
        build_sbox();
        test_inv_mix_columns();
        @(negedge clk);
        test_reset();
        test_fips();
        test_random();
        test_backpressure();
        test_busy_input();
        test_back_to_back();
        test_reset_mid_run();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
